// File: rtl/cgra_cfg_pkg.sv
// Shared CGRA configuration: default geometry, index widths and loader state encoding.
package cgra_cfg_pkg;

    localparam int WIDTH_DEF  = 120;
    localparam int NUM_PE_DEF = 16;
    localparam int DEPTH_DEF  = 16;
    localparam int PE_W       = 4;
    localparam int SLOT_W     = 4;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FLUSH = 3'd2,
        S_START = 3'd3,
        S_RUN   = 3'd4
    } state_t;

endpackage

// File: rtl/context_loader_if.sv
// Host handshake and PE broadcast bus of the context loader.
interface context_loader_if import cgra_cfg_pkg::*; #(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int NUM_PE = NUM_PE_DEF
) ();

    logic              host_valid;
    logic              host_ready;
    logic [WIDTH:0]    host_data;
    logic [PE_W-1:0]   host_pe;
    logic              host_last;
    logic [WIDTH:0]    data;
    logic [NUM_PE-1:0] pe_sel;
    logic [SLOT_W-1:0] slot;
    logic              start;

    modport master (
        output host_valid, host_data, host_pe, host_last,
        input  host_ready, data, pe_sel, slot, start
    );

    modport slave (
        input  host_valid, host_data, host_pe, host_last,
        output host_ready, data, pe_sel, slot, start
    );

endinterface

// File: rtl/slot_counter_bank.sv
// Per-PE next-slot counters; full marks that the last slot has already been written.
module slot_counter_bank import cgra_cfg_pkg::*; #(
    parameter int NUM_PE = NUM_PE_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              inc_en,
    input  logic [PE_W-1:0]   pe_idx,
    input  logic              clr,
    output logic [SLOT_W-1:0] cnt,
    output logic              full
);

    logic [SLOT_W-1:0] cnt_q [NUM_PE];
    logic [NUM_PE-1:0] full_q;

    always_comb begin
        cnt  = '0;
        full = 1'b0;
        for (int i = 0; i < NUM_PE; i++) begin
            if (pe_idx == PE_W'(i)) begin
                cnt  = cnt_q[i];
                full = full_q[i];
            end
        end
    end

    // The counter saturates at DEPTH-1; the full bit records that slot as consumed.
    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            for (int i = 0; i < NUM_PE; i++) cnt_q[i] <= '0;
            full_q <= '0;
        end else if (inc_en) begin
            for (int i = 0; i < NUM_PE; i++) begin
                if (pe_idx == PE_W'(i)) begin
                    if (cnt_q[i] == SLOT_W'(DEPTH - 1)) full_q[i] <= 1'b1;
                    else                                cnt_q[i]  <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/context_loader.sv
// Streams host context words into per-PE slots, then fires a global start pulse.
// Optional CTX_PARITY_EN: host_data[WIDTH] is an even-parity bit over the payload.
module context_loader import cgra_cfg_pkg::*; #(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int NUM_PE = NUM_PE_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic             CLK,
    input  logic             RST,
    context_loader_if.slave  bus,
    input  logic             run_stop,
    output logic             busy,
    output logic             err
);

    state_t            state;
    logic              accept, pe_ok, parity_ok, wr_ok, full, clr;
    logic [SLOT_W-1:0] cnt;

    function automatic logic [NUM_PE-1:0] pe_onehot(input logic [PE_W-1:0] idx);
        logic [NUM_PE-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_PE; i++) if (idx == PE_W'(i)) v[i] = 1'b1;
        return v;
    endfunction

    assign accept = bus.host_valid && bus.host_ready;
    assign pe_ok  = int'(bus.host_pe) < NUM_PE;
`ifdef CTX_PARITY_EN
    assign parity_ok = ~^bus.host_data;
`else
    assign parity_ok = 1'b1;
`endif
    // Rejected words are still consumed from the host so the load sequence never stalls.
    assign wr_ok  = accept && pe_ok && !full && parity_ok;
    assign clr    = (state == S_RUN) && run_stop;

    slot_counter_bank #(.NUM_PE(NUM_PE), .DEPTH(DEPTH)) u_bank (
        .CLK    (CLK),
        .RST    (RST),
        .inc_en (wr_ok),
        .pe_idx (bus.host_pe),
        .clr    (clr),
        .cnt    (cnt),
        .full   (full)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= S_IDLE;
            bus.host_ready <= 1'b1;
            bus.data       <= '0;
            bus.pe_sel     <= '0;
            bus.slot       <= '0;
            bus.start      <= 1'b0;
            busy           <= 1'b0;
            err            <= 1'b0;
        end else begin
            bus.pe_sel <= '0;
            bus.start  <= 1'b0;
            if (wr_ok) begin
                bus.data   <= bus.host_data;
                bus.pe_sel <= pe_onehot(bus.host_pe);
                bus.slot   <= cnt;
            end
            if (accept && !wr_ok) err <= 1'b1;

            case (state)
                S_IDLE, S_LOAD: begin
                    if (accept) begin
                        busy <= 1'b1;
                        if (bus.host_last) begin
                            state          <= S_FLUSH;
                            bus.host_ready <= 1'b0;
                        end else begin
                            state <= S_LOAD;
                        end
                    end
                end
                S_FLUSH: begin
                    state     <= S_START;
                    bus.start <= 1'b1;
                end
                S_START: state <= S_RUN;
                S_RUN: begin
                    if (run_stop) begin
                        state          <= S_IDLE;
                        busy           <= 1'b0;
                        bus.host_ready <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/context_loader.md
CONTEXT_LOADER -- requirements
Module: context_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 120, meaning the context word is [WIDTH:0], i.e. 121 bits.
REQ-002 SHALL have parameter NUM_PE, default 16, meaning the number of PEs fed; PE index is 4 bits.
REQ-003 SHALL have parameter DEPTH, default 16, meaning the context slots per PE; slot index is 4 bits.
REQ-004 SHALL use one clock and a synchronous, active-high reset: CLK in 1, rising edge; RST in 1, synchronous active-high reset.
REQ-005 SHALL have these host-side ports:
- host_valid in 1: host offers a word.
- host_ready out 1: loader accepts a word this cycle.
- host_data in WIDTH+1: context word.
- host_pe in 4: target PE index.
- host_last in 1: final word of the configuration.
REQ-006 SHALL have these PE-side ports:
- data out WIDTH+1: context broadcast to all PEs.
- pe_sel out NUM_PE: one-hot write strobe per PE.
- slot out 4: context slot being written.
- start out 1: one-cycle global start pulse to all PEs.
REQ-007 SHALL have these status ports:
- run_stop in 1: array finished; return to IDLE.
- busy out 1: not in IDLE.
- err out 1: sticky error flag.

Function
REQ-008 SHALL implement the states IDLE, LOAD, FLUSH, START and RUN.
REQ-009 SHALL accept a word when host_valid and host_ready are both high on a CLK edge; host_ready SHALL be 1 only in IDLE and LOAD.
REQ-010 SHALL move from IDLE to LOAD on the first accepted word.
REQ-011 SHALL, for each accepted word, drive data=host_data, pe_sel=one-hot(host_pe) and slot=slot_cnt[host_pe] on the next cycle (1-cycle latency), then increment slot_cnt[host_pe].
REQ-012 SHALL hold pe_sel at all zeros in every cycle that follows a cycle without an accepted word; data and slot SHALL hold their last value.
REQ-013 SHALL treat host_pe >= NUM_PE as an error: err is set, pe_sel stays zero, and no counter changes.
REQ-014 SHALL treat a word for a PE whose slot_cnt equals DEPTH-1 and is already written as an overflow: err is set and the word is dropped; slot_cnt SHALL NOT wrap.
REQ-015 SHALL, on accepting a word with host_last=1, move to FLUSH, in which the final strobe appears.
REQ-016 SHALL go from FLUSH to START unconditionally, and from START to RUN unconditionally.
REQ-017 SHALL assert start for exactly the single START cycle.
REQ-018 SHALL, in RUN, move to IDLE on run_stop=1 and clear all slot_cnt; run_stop SHALL be ignored in every other state.
REQ-019 SHALL hold busy=1 in every state except IDLE.
REQ-020 SHALL keep err set until RST; an error SHALL NOT abort the load sequence.

Reset
REQ-021 SHALL, on RST=1 at a CLK edge, set: state=IDLE, all slot_cnt=0, data=0, pe_sel=0, slot=0, start=0, err=0, busy=0, host_ready=1.
REQ-022 SHALL let RST take priority over all other inputs, including mid-LOAD and during START; no start pulse SHALL follow a reset.

Configuration
REQ-023 SHALL, when CTX_PARITY_EN is defined, treat host_data[WIDTH] as an even-parity bit over host_data[WIDTH-1:0].
REQ-024 SHALL, when CTX_PARITY_EN is defined and parity mismatches, set err, drop the word, and leave slot_cnt unchanged.
REQ-025 SHALL, when CTX_PARITY_EN is undefined, carry all WIDTH+1 bits as payload with no check.

Structure
REQ-026 SHALL place the state encoding, the PE index and slot widths, and the WIDTH/NUM_PE/DEPTH defaults in the shared package cgra_cfg_pkg.
REQ-027 SHALL implement the per-PE slot counter array as the sub-module slot_counter_bank, with inputs inc_en, pe_idx and clr and outputs cnt and full.

Verification
REQ-028 SHALL cover: after reset, send 3 words to PE 2 then 1 word to PE 5 with last -> pe_sel=0x0004 with slot=0,1,2, then 0x0020 with slot 0; start pulses exactly 2 cycles after the last word is accepted.
REQ-029 SHALL cover: 17 words to PE 0 -> slots 0..15 are written, the 17th word is dropped, and err=1.
REQ-030 SHALL cover: host_pe=4'hF with NUM_PE=8 -> err=1, pe_sel stays 0, and the next valid word gets slot 0.
REQ-031 SHALL cover: RST asserted mid-LOAD, then a new load -> no start from the aborted load, and slots restart at 0.
REQ-032 SHALL cover: host_valid held high during RUN -> host_ready=0 and nothing is accepted; run_stop -> IDLE, busy=0, and the counters are cleared.
REQ-033 SHALL cover, with CTX_PARITY_EN defined: a word with bad parity -> err=1, no strobe, and the slot is not consumed.
